// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package rv_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // Producer identity, used as the round-robin last-grant state.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of producer handshakes, register-file write port and forwarding lookup.
// The write-back block sits on the slave side; its environment drives the master side.
interface regfile_writeback_if #(
  parameter int unsigned DEPTH = 4
);
  import rv_wb_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // ALU producer
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  // Load producer
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  // Register-file write port
  logic                  rf_stall;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] addr_rd;
  logic [XLEN-1:0]       data_rd;
  // Forwarding lookup and status
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic                  fwd_hit;
  logic [XLEN-1:0]       fwd_data;
  logic [CntW-1:0]       pending_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output rf_stall, fwd_addr,
    input  alu_ready, mem_ready,
    input  write_enable, addr_rd, data_rd,
    input  fwd_hit, fwd_data, pending_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  rf_stall, fwd_addr,
    output alu_ready, mem_ready,
    output write_enable, addr_rd, data_rd,
    output fwd_hit, fwd_data, pending_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending write-back entries. All storage plus the head/tail
// pointers are exposed so the owner can search pending writes. Occupancy is tracked
// by an explicit count; the pointers simply wrap.
module wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  wb_entry_t                    push_entry_i,
  input  logic                         pop_i,
  output wb_entry_t                    head_entry_o,
  output wb_entry_t                    entries_o [DEPTH],
  output logic [$clog2(DEPTH)-1:0]     head_ptr_o,
  output logic [$clog2(DEPTH)-1:0]     tail_ptr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full FIFO is only safe when an entry leaves on the same edge.
  assign do_push = push_i && (!full || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop) begin
      head_d = head_q + PtrW'(1);
    end
    if (do_push) begin
      tail_d = tail_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

  assign head_entry_o = mem_q[head_q];
  assign entries_o    = mem_q;
  assign head_ptr_o   = head_q;
  assign tail_ptr_o   = tail_q;
  assign count_o      = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-side driver for the register file. Round-robin arbitrates ALU and load results,
// queues them in wb_fifo and issues at most one registered write per cycle.
// Writes to x0 complete the handshake but are dropped.
// Optional: define REGFILE_WB_FWD_EN to enable the forwarding search over pending
// writes; without it fwd_hit/fwd_data are tied low.
module regfile_writeback
  import rv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  regfile_writeback_if.slave  wb
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wb_src_e               last_grant_q, last_grant_d;
  logic                  grant_alu, grant_mem;
  logic                  alu_ready, mem_ready;
  logic                  alu_acc, mem_acc;
  logic                  full, push, pop;
  wb_entry_t             push_entry, head_entry;
  wb_entry_t             fifo_mem [DEPTH];
  logic [PtrW-1:0]       head_ptr, tail_ptr;
  logic [CntW-1:0]       count;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       data_q, data_d;

  logic                  fwd_hit;
  logic [XLEN-1:0]       fwd_data;

  // Grant: on contention the producer not served last time wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (wb.alu_valid && wb.mem_valid) begin
      if (last_grant_q == WB_SRC_ALU) begin
        grant_mem = 1'b1;
      end else begin
        grant_alu = 1'b1;
      end
    end else begin
      grant_alu = wb.alu_valid;
      grant_mem = wb.mem_valid;
    end
  end

  // Ready comes from the registered count only, so a pop in flight never frees a slot early.
  assign full      = (count == CntW'(DEPTH));
  assign alu_ready = !full && grant_alu;
  assign mem_ready = !full && grant_mem;
  assign alu_acc   = wb.alu_valid && alu_ready;
  assign mem_acc   = wb.mem_valid && mem_ready;

  // Select the accepted producer's result; x0 destinations are not queued.
  always_comb begin
    push_entry = '{rd: wb.alu_rd, data: wb.alu_data};
    if (grant_mem) begin
      push_entry = '{rd: wb.mem_rd, data: wb.mem_data};
    end
    push = (alu_acc && (wb.alu_rd != '0)) || (mem_acc && (wb.mem_rd != '0));
  end

  // Last-grant pointer moves only on a completed handshake.
  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_acc) begin
      last_grant_d = WB_SRC_ALU;
    end else if (mem_acc) begin
      last_grant_d = WB_SRC_MEM;
    end
  end

  // Reset to "MEM served last" so the ALU is favoured first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= WB_SRC_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign pop = (count != '0) && !wb.rf_stall;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clock),
    .rst_ni       (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_entry_o (head_entry),
    .entries_o    (fifo_mem),
    .head_ptr_o   (head_ptr),
    .tail_ptr_o   (tail_ptr),
    .count_o      (count)
  );

  // Output register next-state: load the head on a pop, otherwise hold address/data.
  always_comb begin
    we_d   = pop;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      addr_d = head_entry.rd;
      data_d = head_entry.data;
    end
  end

  // Register-file write port registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  logic [PtrW-1:0] fwd_idx;

  // Youngest match wins: output register is oldest, then FIFO from head to tail.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (wb.fwd_addr != '0) begin
      if (we_q && (addr_q == wb.fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fwd_idx = head_ptr + PtrW'(i);
        if ((CntW'(i) < count) && (fifo_mem[fwd_idx].rd == wb.fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_mem[fwd_idx].data;
        end
      end
    end
  end
`else
  logic unused_fwd;

  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;

  // Search inputs have no consumer in this build.
  always_comb begin
    unused_fwd = (^wb.fwd_addr) ^ (^head_ptr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      unused_fwd = unused_fwd ^ (^fifo_mem[i]);
    end
  end
`endif

  logic unused_tail;
  assign unused_tail = ^tail_ptr;

  assign wb.alu_ready     = alu_ready;
  assign wb.mem_ready     = mem_ready;
  assign wb.write_enable  = we_q;
  assign wb.addr_rd       = addr_q;
  assign wb.data_rd       = data_q;
  assign wb.fwd_hit       = fwd_hit;
  assign wb.fwd_data      = fwd_data;
  assign wb.pending_count = count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic checked
// against a queue-based model of the write-back behaviour.
module tb_regfile_writeback;

  localparam int D = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_writeback_if #(.DEPTH(D)) wb ();

  regfile_writeback #(.DEPTH(D)) dut (
    .clock (clk),
    .reset (rst_n),
    .wb    (wb)
  );

  // Model: pending writes in acceptance order, the last issued write, and who is favoured.
  ent_t m_q[$];
  ent_t m_out;
  bit   m_we;
  bit   m_alu_next;
  ent_t obs[$];

  task automatic model_reset();
    m_q.delete();
    obs.delete();
    m_we       = 1'b0;
    m_out.rd   = '0;
    m_out.data = '0;
    m_alu_next = 1'b1;
  endtask

  // 0 = nobody accepted, 1 = ALU, 2 = MEM
  function automatic int model_grant();
    if (m_q.size() == D) return 0;
    if (wb.alu_valid && wb.mem_valid) return m_alu_next ? 1 : 2;
    if (wb.alu_valid) return 1;
    if (wb.mem_valid) return 2;
    return 0;
  endfunction

  function automatic void model_fwd(input logic [4:0] a, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef REGFILE_WB_FWD_EN
    if (a != 0) begin
      for (int i = m_q.size() - 1; i >= 0; i--) begin
        if (m_q[i].rd == a) begin
          hit = 1'b1;
          d   = m_q[i].data;
          return;
        end
      end
      if (m_we && m_out.rd == a) begin
        hit = 1'b1;
        d   = m_out.data;
      end
    end
`endif
  endfunction

  task automatic idle();
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.mem_valid = 1'b0; wb.mem_rd = '0; wb.mem_data = '0;
    wb.rf_stall  = 1'b0; wb.fwd_addr = '0;
  endtask

  // Advance one clock; called at posedge+1 and returns at the next posedge+1.
  task automatic tick();
    int   g;
    bit   pop;
    ent_t a_e, m_e;
    g         = model_grant();
    pop       = (m_q.size() > 0) && !wb.rf_stall;
    a_e.rd    = wb.alu_rd; a_e.data = wb.alu_data;
    m_e.rd    = wb.mem_rd; m_e.data = wb.mem_data;
    @(posedge clk);
    #1;
    if (pop) begin
      m_out = m_q.pop_front();
      m_we  = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (g == 1) begin
      if (a_e.rd != 0) m_q.push_back(a_e);
      m_alu_next = 1'b0;
    end else if (g == 2) begin
      if (m_e.rd != 0) m_q.push_back(m_e);
      m_alu_next = 1'b1;
    end
    if (wb.write_enable === 1'b1) begin
      ent_t o;
      o.rd = wb.addr_rd; o.data = wb.data_rd;
      obs.push_back(o);
    end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    checks++; if (wb.write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", wb.write_enable); end
    checks++; if (wb.pending_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", wb.pending_count); end
    checks++; if (wb.addr_rd !== 5'd0 || wb.data_rd !== 32'd0) begin failures++; $display("FAIL reset_out got=%0d/%h exp=0/0", wb.addr_rd, wb.data_rd); end
    checks++; if (wb.fwd_hit !== 1'b0) begin failures++; $display("FAIL reset_fwd got=%b exp=0", wb.fwd_hit); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_alu();
    do_reset();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (wb.alu_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", wb.alu_ready); end
    tick();
    idle();
    #1;
    checks++; if (wb.write_enable !== 1'b0 || wb.pending_count !== 3'd1) begin failures++; $display("FAIL single_k got we=%b cnt=%0d exp we=0 cnt=1", wb.write_enable, wb.pending_count); end
    tick();
    checks++; if (wb.write_enable !== 1'b1 || wb.addr_rd !== 5'd5 || wb.data_rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_write got we=%b rd=%0d d=%h exp we=1 rd=5 d=deadbeef", wb.write_enable, wb.addr_rd, wb.data_rd);
    end
    checks++; if (wb.pending_count !== 3'd0) begin failures++; $display("FAIL single_drain got=%0d exp=0", wb.pending_count); end
    tick();
    checks++; if (wb.write_enable !== 1'b0) begin failures++; $display("FAIL single_once got=%b exp=0", wb.write_enable); end
  endtask

  task automatic test_alternate();
    int          ai, mi, g;
    logic [31:0] ad [4];
    logic [31:0] md [4];
    logic [4:0]  exp_rd [8];
    logic [31:0] exp_d  [8];
    do_reset();
    ai = 0; mi = 0;
    for (int cyc = 0; cyc < 40 && (ai < 4 || mi < 4); cyc++) begin
      if (ai < 4) begin
        wb.alu_valid = 1'b1; wb.alu_rd = 5'(1 + ai);
        if (wb.alu_data == 0 || wb.alu_rd != 5'(1 + ai)) wb.alu_data = $urandom;
      end else wb.alu_valid = 1'b0;
      if (mi < 4) begin
        wb.mem_valid = 1'b1; wb.mem_rd = 5'(11 + mi);
      end else wb.mem_valid = 1'b0;
      wb.alu_data = 32'hA000_0000 | 32'(ai);
      wb.mem_data = 32'hB000_0000 | 32'(mi);
      #1;
      g = model_grant();
      checks++; if (wb.alu_ready !== (g == 1) || wb.mem_ready !== (g == 2)) begin
        failures++; $display("FAIL alt_ready cyc=%0d got=%b%b exp_grant=%0d", cyc, wb.alu_ready, wb.mem_ready, g);
      end
      if (g == 1) begin ad[ai] = wb.alu_data; ai++; end
      if (g == 2) begin md[mi] = wb.mem_data; mi++; end
      tick();
    end
    checks++; if (ai != 4 || mi != 4) begin failures++; $display("FAIL alt_timeout got alu=%0d mem=%0d exp 4/4", ai, mi); end
    idle();
    for (int c = 0; c < 20 && obs.size() < 8; c++) tick();
    for (int i = 0; i < 4; i++) begin
      exp_rd[2*i] = 5'(1 + i);  exp_d[2*i] = 32'hA000_0000 | 32'(i);
      exp_rd[2*i+1] = 5'(11 + i); exp_d[2*i+1] = 32'hB000_0000 | 32'(i);
    end
    checks++; if (obs.size() != 8) begin failures++; $display("FAIL alt_count got=%0d exp=8", obs.size()); end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      checks++; if (obs[i].rd !== exp_rd[i] || obs[i].data !== exp_d[i]) begin
        failures++; $display("FAIL alt_order idx=%0d got=%0d/%h exp=%0d/%h", i, obs[i].rd, obs[i].data, exp_rd[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_full();
    int g;
    bit sent;
    do_reset();
    wb.rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wb.alu_valid = 1'b1; wb.alu_rd = 5'(i); wb.alu_data = 32'(100 + i);
      #1;
      checks++; if (wb.alu_ready !== 1'b1) begin failures++; $display("FAIL full_fill i=%0d got=%b exp=1", i, wb.alu_ready); end
      tick();
    end
    wb.alu_rd = 5'd5; wb.alu_data = 32'd105;
    #1;
    checks++; if (wb.pending_count !== 3'd4 || wb.alu_ready !== 1'b0) begin
      failures++; $display("FAIL full_state got cnt=%0d rdy=%b exp cnt=4 rdy=0", wb.pending_count, wb.alu_ready);
    end
    tick();
    wb.rf_stall = 1'b0;
    #1;
    checks++; if (wb.alu_ready !== 1'b0) begin failures++; $display("FAIL full_pop_rdy got=%b exp=0", wb.alu_ready); end
    sent = 1'b0;
    for (int c = 0; c < 10; c++) begin
      g = model_grant();
      checks++; if (wb.alu_ready !== (g == 1) || wb.pending_count !== 3'(m_q.size())) begin
        failures++; $display("FAIL full_drain c=%0d got rdy=%b cnt=%0d exp rdy=%b cnt=%0d", c, wb.alu_ready, wb.pending_count, g == 1, m_q.size());
      end
      tick();
      if (g == 1) sent = 1'b1;
      if (sent) wb.alu_valid = 1'b0;
      #1;
    end
    checks++; if (!sent) begin failures++; $display("FAIL full_reassert got=0 exp=1"); end
    checks++; if (obs.size() != 5) begin failures++; $display("FAIL full_writes got=%0d exp=5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      checks++; if (obs[i].rd !== 5'(i + 1) || obs[i].data !== 32'(101 + i)) begin
        failures++; $display("FAIL full_order idx=%0d got=%0d/%0d exp=%0d/%0d", i, obs[i].rd, obs[i].data, i + 1, 101 + i);
      end
    end
  endtask

  task automatic test_x0();
    do_reset();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h1234;
    #1;
    checks++; if (wb.alu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", wb.alu_ready); end
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (wb.write_enable !== 1'b0 || wb.pending_count !== 3'd0 || wb.fwd_hit !== 1'b0) begin
        failures++; $display("FAIL x0_drop c=%0d got we=%b cnt=%0d hit=%b exp 0/0/0", c, wb.write_enable, wb.pending_count, wb.fwd_hit);
      end
      tick();
    end
  endtask

  task automatic test_fwd();
    bit          eh;
    logic [31:0] ed;
    do_reset();
    wb.rf_stall = 1'b1;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_data = 32'h10;
    tick();
    wb.alu_data = 32'h20;
    tick();
    wb.alu_valid = 1'b0;
    wb.fwd_addr = 5'd7;
    #1;
`ifdef REGFILE_WB_FWD_EN
    eh = 1'b1; ed = 32'h20;
`else
    eh = 1'b0; ed = 32'h0;
`endif
    checks++; if (wb.fwd_hit !== eh || wb.fwd_data !== ed) begin
      failures++; $display("FAIL fwd_young got=%b/%h exp=%b/%h", wb.fwd_hit, wb.fwd_data, eh, ed);
    end
    wb.mem_valid = 1'b1; wb.mem_rd = 5'd9; wb.mem_data = 32'h30;
    tick();
    wb.mem_valid = 1'b0;
    wb.rf_stall = 1'b0;
    for (int c = 0; c < 6; c++) begin
      wb.fwd_addr = (c % 2 == 0) ? 5'd7 : 5'd9;
      #1;
      model_fwd(wb.fwd_addr, eh, ed);
      checks++; if (wb.fwd_hit !== eh || wb.fwd_data !== ed) begin
        failures++; $display("FAIL fwd_drain c=%0d got=%b/%h exp=%b/%h", c, wb.fwd_hit, wb.fwd_data, eh, ed);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int          g;
    bit          eh;
    logic [31:0] ed;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      wb.alu_valid = 1'($urandom_range(0, 1)); wb.alu_rd = 5'($urandom_range(0, 7)); wb.alu_data = $urandom;
      wb.mem_valid = 1'($urandom_range(0, 1)); wb.mem_rd = 5'($urandom_range(0, 7)); wb.mem_data = $urandom;
      wb.rf_stall  = ($urandom_range(0, 3) == 0);
      wb.fwd_addr  = 5'($urandom_range(0, 7));
      #1;
      g = model_grant();
      model_fwd(wb.fwd_addr, eh, ed);
      checks++; if (wb.alu_ready !== (g == 1) || wb.mem_ready !== (g == 2)) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b%b exp_grant=%0d", cyc, wb.alu_ready, wb.mem_ready, g);
      end
      checks++; if (wb.write_enable !== m_we || wb.addr_rd !== m_out.rd || wb.data_rd !== m_out.data) begin
        failures++; $display("FAIL rand_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, wb.write_enable, wb.addr_rd, wb.data_rd, m_we, m_out.rd, m_out.data);
      end
      checks++; if (wb.pending_count !== 3'(m_q.size())) begin
        failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, wb.pending_count, m_q.size());
      end
      checks++; if (wb.fwd_hit !== eh || wb.fwd_data !== ed) begin
        failures++; $display("FAIL rand_fwd cyc=%0d addr=%0d got=%b/%h exp=%b/%h", cyc, wb.fwd_addr, wb.fwd_hit, wb.fwd_data, eh, ed);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit          eh;
    logic [31:0] ed;
    do_reset();
    wb.rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb.alu_valid = 1'b1; wb.alu_rd = 5'(3 + i); wb.alu_data = 32'(200 + i);
      tick();
    end
    wb.alu_valid = 1'b0;
    wb.rf_stall = 1'b0;
    tick();
    wb.rf_stall = 1'b1;
    wb.fwd_addr = 5'd5;
    #1;
    model_fwd(wb.fwd_addr, eh, ed);
    checks++; if (wb.pending_count !== 3'd3 || wb.write_enable !== 1'b1 || wb.fwd_hit !== eh) begin
      failures++; $display("FAIL midrst_pre got cnt=%0d we=%b hit=%b exp cnt=3 we=1 hit=%b", wb.pending_count, wb.write_enable, wb.fwd_hit, eh);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wb.write_enable !== 1'b0 || wb.pending_count !== 3'd0 || wb.fwd_hit !== 1'b0) begin
      failures++; $display("FAIL midrst_async got we=%b cnt=%0d hit=%b exp 0/0/0", wb.write_enable, wb.pending_count, wb.fwd_hit);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb.rf_stall = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (wb.write_enable !== 1'b0 || wb.pending_count !== 3'd0) begin
        failures++; $display("FAIL midrst_stale c=%0d got we=%b cnt=%0d exp 0/0", c, wb.write_enable, wb.pending_count);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_alternate();
    test_full();
    test_x0();
    test_fwd();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side driver for the processor's register file. Feeds the register file's `write_enable`/`addr_rd`/`data_rd` port.
- Accepts retiring results from two producers: the ALU path and the load path. Each uses a valid/ready handshake.
- Arbitrates between them and buffers results in a small FIFO. Issues at most one register-file write per cycle.
- Exposes a forwarding lookup so decode can read values that are accepted but not yet written.

Parameters:
- XLEN, 32, data width of a register.
- REG_ADDR_W, 5, register index width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; block is in reset while low.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted this cycle when high together with alu_valid.
- alu_rd  input  REG_ADDR_W  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load result offered.
- mem_ready  output  1  load handshake ready.
- mem_rd  input  REG_ADDR_W  load destination register.
- mem_data  input  XLEN  load data.
- rf_stall  input  1  register-file port unavailable this cycle; no pop.
- write_enable  output  1  register-file write strobe (registered).
- addr_rd  output  REG_ADDR_W  register-file write address (registered).
- data_rd  output  XLEN  register-file write data (registered).
- fwd_addr  input  REG_ADDR_W  forwarding lookup index.
- fwd_hit  output  1  a pending write to fwd_addr exists.
- fwd_data  output  XLEN  youngest pending value for fwd_addr.
- pending_count  output  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- **Reset.** While reset is low, asynchronously clear:
  - FIFO pointers and count;
  - write_enable, addr_rd, data_rd, pending_count (all to 0);
  - arbitration pointer (to ALU-first).
  - Any in-flight entries are discarded. fwd_hit is 0.
- **Arbitration.** Round-robin with a 1-bit last-grant flop.
  - Only one producer is accepted per cycle.
  - When both are valid, the producer not granted last time wins. The pointer updates only on an accepted transfer.
  - When only one is valid, it wins.
  - alu_ready = not full AND ALU granted. mem_ready likewise.
  - Ready may depend combinationally on both valids. Ready is never high while full.
- **x0 writes.** rd==0 completes the handshake but is not enqueued and never produces write_enable.
- **Enqueue.** {rd, data} is written at the tail on the accepting edge.
- **Pop.** Each edge where count>0 and rf_stall==0:
  - the head moves into the addr_rd/data_rd registers and write_enable=1 for the next cycle;
  - otherwise write_enable=0 next cycle.
- **Latency.** Accepted at edge k with an empty FIFO and no stall → write_enable high in the cycle following edge k+1.
- **Simultaneous push and pop.** Allowed; count is unchanged. Full with a pop in progress still reports ready=0; ready is computed from the registered count.
- **Wrap-around.** Pointers are log2(DEPTH) bits and wrap naturally. The full/empty distinction comes from count.
- **Forwarding.** Search the FIFO entries plus the output register while write_enable is high.
  - The youngest match wins: tail-most FIFO entry first, output register last.
  - fwd_addr==0 → fwd_hit=0, fwd_data=0.
  - The lookup is purely combinational, from registered state only.
- **Ordering.** Register-file writes occur in acceptance order.

Optional Feature:
- Macro REGFILE_WB_FWD_EN.
- Defined: forwarding search as specified.
- Undefined: fwd_hit and fwd_data are tied to 0, the search logic is absent, and the fwd_addr port still exists.

Decomposition:
- Package rv_wb_pkg contains:
  - constants XLEN and REG_ADDR_W;
  - typedef wb_entry_t (packed struct of rd and data);
  - typedef wb_src_e enum {WB_SRC_ALU, WB_SRC_MEM}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t, parameter DEPTH. It exposes all entries plus head/tail pointers for the forwarding search, and takes the same asynchronous active-low reset.

Test Plan:
- Single ALU write: alu_valid, rd=5, data=0xDEADBEEF, no stall → one cycle of write_enable=1, addr_rd=5, data_rd=0xDEADBEEF two edges later; pending_count returns to 0.
- Both valid for 4 cycles: ALU rd=1..4 and MEM rd=11..14 held → grants alternate ALU, MEM, ALU, MEM…; writes appear in that order; no result is dropped.
- Full: rf_stall=1, push rd=1..4 → pending_count=4 and alu_ready=0. Then release the stall → writes rd=1..4 in order and ready reasserts once count<4.
- x0: push rd=0 data=0x1234 → handshake completes; write_enable never asserts; pending_count stays 0; fwd_addr=0 gives fwd_hit=0.
- Forwarding: with stall, push rd=7 data=0x10 then rd=7 data=0x20 → fwd_addr=7 gives hit=1, data=0x20. With the macro undefined → hit=0.
- Reset mid-operation: with 3 entries pending, drive reset low between edges → write_enable, pending_count and fwd_hit go to 0 immediately. After release, no stale writes occur.
